uart_mem_loader: RTL and testbench

Boot loader stage that sits directly upstream of the on-chip program memory.
- Consumes a byte stream from the UART RX path and parses a framed image.
- Packs bytes into 32-bit little-endian words and writes them sequentially into memory through its Avalon-style slave port.
- Holds the CPU in reset while loading and reports done/error status.

---
 rtl/uart_mem_loader_pkg.sv | 31 +++
 rtl/uart_mem_loader_if.sv | 31 +++
 rtl/uart_mem_loader_pack.sv | 35 +++
 rtl/uart_mem_loader.sv | 151 +++++++++++++++
 tb/tb_uart_mem_loader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Purpose : shared types and constants for the UART boot image loader.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, default frame start marker, byte-lane count,
//           and the timeout-counter width helper.
package uart_mem_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    VRD,
    VCMP,
    CKSUM,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         LANES         = 4;
  localparam int         WORD_W        = 8 * LANES;
  localparam int         IDX_W         = $clog2(LANES);

  // Width needed to count 0 .. cycles-1 (never narrower than one bit).
  function automatic int tmo_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// Purpose : byte-stream input plus Avalon-style memory write port of the loader.
// Latency : n/a (signal bundle).
// Backpressure: rx side is valid/ready; memory side is a fixed-latency slave.
// Ports   : rx_data/rx_valid/rx_ready (byte stream), mem_address/byteenable/
//           chipselect/write/writedata (write bus), mem_readdata (verify read).
//           master modport = loader, slave modport = UART RX + memory side.
interface uart_mem_loader_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;

  modport master (
    input  rx_data, rx_valid, mem_readdata,
    output rx_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata
  );

  modport slave (
    output rx_data, rx_valid, mem_readdata,
    input  rx_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata
  );
endinterface

// File: rtl/uart_mem_loader_pack.sv
// Purpose : packs accepted bytes LSB-first into a 32-bit word, tracks byte lane.
// Latency : word valid the cycle after the 4th load; word_done is combinational.
// Backpressure: none; caller only asserts load on an accepted byte.
// Ports   : clk, reset_n, clear (restart at lane 0), load, din -> word, word_done.
module uart_mem_loader_pack
  import uart_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [IDX_W-1:0] byte_idx;

  assign word_done = load && (byte_idx == IDX_W'(LANES - 1));

  // Shifting right puts the first byte of a group into bits [7:0] once the
  // fourth byte lands, i.e. little-endian packing without a lane mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (load) begin
      word     <= {din, word[WORD_W-1:8]};
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Purpose : parses a framed UART image and writes it word-by-word into program memory.
// Latency : mem_write one cycle after the 4th byte of a word; status one cycle after last byte.
// Backpressure: rx_ready low for 1 cycle per word (3 with LOADER_VERIFY_EN) and in DONE/ERROR.
// Ports   : clk, reset_n (async, active low), bus (uart_mem_loader_if.master),
//           cpu_hold, load_done, load_err, words_loaded.
// Option  : define LOADER_VERIFY_EN to read back and compare every written word.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int         ADDR_W         = 13,
  parameter int         DEPTH          = 5120,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_mem_loader_if.master bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int TW = tmo_width(TIMEOUT_CYCLES);

  state_t            state, nstate;
  logic              rdy, acc, sync_acc, data_acc;
  logic              word_done, last_word, len_bad, tmo_run, tmo_hit;
  logic [7:0]        len_lo, cksum;
  logic [15:0]       len, len_in;
  logic [ADDR_W-1:0] addr, wcnt;
  logic [TW-1:0]     tmo_cnt;
  logic [WORD_W-1:0] word;

  assign rdy      = state inside {IDLE, LEN0, LEN1, DATA, CKSUM};
  assign acc      = bus.rx_valid && rdy;
  assign sync_acc = acc && (state == IDLE) && (bus.rx_data == SYNC_BYTE);
  assign data_acc = acc && (state == DATA);
  assign len_in   = {bus.rx_data, len_lo};
  assign len_bad  = (len_in == 16'd0) || (32'(len_in) > DEPTH);
  assign tmo_run  = state inside {LEN0, LEN1, DATA, CKSUM};
  assign tmo_hit  = tmo_run && !acc && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef LOADER_VERIFY_EN
  // Evaluated in VCMP, after wcnt has already counted the current word.
  assign last_word = (32'(wcnt) == 32'(len));
`else
  // Evaluated in WRITE, before wcnt counts the current word.
  logic unused_rd;
  assign unused_rd = ^bus.mem_readdata;
  assign last_word = (32'(wcnt) + 32'd1 == 32'(len));
`endif

  assign bus.rx_ready       = rdy;
  assign bus.mem_address    = addr;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_chipselect = (state == WRITE) || (state == VRD);
  assign bus.mem_write      = (state == WRITE);
  assign bus.mem_writedata  = word;
  assign words_loaded       = wcnt;

  uart_mem_loader_pack u_pack (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (sync_acc),
    .load      (data_acc),
    .din       (bus.rx_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (sync_acc) nstate = LEN0;
      LEN0:  if (acc) nstate = LEN1;
             else if (tmo_hit) nstate = ERROR;
      LEN1:  if (acc) nstate = len_bad ? ERROR : DATA;
             else if (tmo_hit) nstate = ERROR;
      DATA:  if (word_done) nstate = WRITE;
             else if (tmo_hit) nstate = ERROR;
`ifdef LOADER_VERIFY_EN
      WRITE: nstate = VRD;
      VRD:   nstate = VCMP;
      VCMP:  if (bus.mem_readdata != word) nstate = ERROR;
             else nstate = last_word ? CKSUM : DATA;
`else
      WRITE: nstate = last_word ? CKSUM : DATA;
`endif
      CKSUM: if (acc) nstate = (bus.rx_data == cksum) ? DONE : ERROR;
             else if (tmo_hit) nstate = ERROR;
      DONE:  nstate = IDLE;
      ERROR: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Idle-gap counter: only runs while waiting for a byte inside a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                tmo_cnt <= '0;
    else if (!tmo_run || acc)    tmo_cnt <= '0;
    else if (!tmo_hit)           tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      wcnt      <= '0;
      addr      <= '0;
      cksum     <= '0;
      len       <= '0;
      len_lo    <= '0;
    end else begin
      if (sync_acc) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
        wcnt      <= '0;
        addr      <= '0;
        cksum     <= '0;
        cpu_hold  <= 1'b1;
      end
      if (acc && (state == LEN0)) len_lo <= bus.rx_data;
      if (acc && (state == LEN1)) len    <= len_in;
      if (data_acc) cksum <= cksum + bus.rx_data;
      if ((state == WRITE) && (wcnt != ADDR_W'(DEPTH))) wcnt <= wcnt + ADDR_W'(1);
`ifdef LOADER_VERIFY_EN
      // Address must stay put through the read-back cycle.
      if (state == VRD) addr <= addr + ADDR_W'(1);
`else
      if (state == WRITE) addr <= addr + ADDR_W'(1);
`endif
      // Status is raised on entry so it is already visible in DONE/ERROR.
      if (nstate == DONE) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
      if (nstate == ERROR) begin
        load_err <= 1'b1;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Purpose : self-checking bench for uart_mem_loader against a frame-level model.
// Latency : n/a.
// Backpressure: driver honours rx_ready; memory model has 1-cycle read latency.
module tb_uart_mem_loader;

  localparam int         ADDR_W = 13;
  localparam int         DEPTH  = 5120;
  localparam int         TMO    = 64;
  localparam logic [7:0] SYNC   = 8'hA5;
`ifdef LOADER_VERIFY_EN
  localparam int CYC = 3;
`else
  localparam int CYC = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] words_loaded;

  always #5 clk = ~clk;

  uart_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_mem_loader #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Memory model: posted writes, 1-cycle registered reads.
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [3:0]  wr_be_log[$];
  assign bus.mem_readdata = rd_q;

  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_write) begin
      mem[bus.mem_address] <= bus.mem_writedata;
      wr_addr_log.push_back(32'(bus.mem_address));
      wr_data_log.push_back(bus.mem_writedata);
      wr_be_log.push_back(bus.mem_byteenable);
    end
    if (bus.mem_chipselect && !bus.mem_write) rd_q <= mem[bus.mem_address];
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  frm[$];
  bit          exp_done, exp_err;
  int          exp_words;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          stalls, hold_drops;
  bit          synced;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: find the marker, decode length, slice payload into
  // little-endian words and sum the payload bytes mod 256.
  function automatic void model(input logic [7:0] f[$]);
    int         i = 0;
    int         len;
    logic [7:0] sum = 8'd0;
    exp_addr.delete();
    exp_data.delete();
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 0;
    while (i < f.size() && f[i] != SYNC) i++;
    len = int'(f[i+1]) + 256 * int'(f[i+2]);
    if (len == 0 || len > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < len; w++) begin
      exp_addr.push_back(32'(w));
      exp_data.push_back({f[i+6+4*w], f[i+5+4*w], f[i+4+4*w], f[i+3+4*w]});
      for (int b = 0; b < 4; b++) sum = sum + f[i+3+4*w+b];
    end
    exp_words = len;
    if (f[i+3+4*len] == sum) exp_done = 1'b1;
    else                     exp_err  = 1'b1;
  endfunction

  task automatic build_frame(input int npre, input int len, input bit bad_ck);
    logic [7:0] b, s;
    frm.delete();
    repeat (npre) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      frm.push_back(b);
    end
    frm.push_back(SYNC);
    frm.push_back(8'(len));
    frm.push_back(8'(len >> 8));
    if (len >= 1 && len <= DEPTH) begin
      s = 8'd0;
      for (int k = 0; k < 4 * len; k++) begin
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) b = SYNC;
        frm.push_back(b);
        s = s + b;
      end
      frm.push_back(bad_ck ? s + 8'd1 : s);
    end
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int gap);
    stalls     = 0;
    hold_drops = 0;
    synced     = 1'b0;
    foreach (q[k]) begin
      int guard;
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = q[k];
      guard = 0;
      while (!bus.rx_ready && guard < 20) begin
        @(negedge clk);
        stalls++;
        guard++;
      end
      if (guard == 20) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
      if (synced && !cpu_hold) hold_drops++;
      if (q[k] == SYNC) synced = 1'b1;
      @(posedge clk);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap, input string name);
    int nbad;
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_be_log.delete();
    model(frm);
    send_stream(frm, gap);
    repeat (5) @(negedge clk);
    check($sformatf("%s:load_done", name), 32'(load_done), 32'(exp_done));
    check($sformatf("%s:load_err", name), 32'(load_err), 32'(exp_err));
    check($sformatf("%s:words_loaded", name), 32'(words_loaded), 32'(exp_words));
    check($sformatf("%s:cpu_hold_after", name), 32'(cpu_hold), 32'd0);
    check($sformatf("%s:hold_drops", name), 32'(hold_drops), 32'd0);
    check($sformatf("%s:n_writes", name), 32'(wr_data_log.size()), 32'(exp_data.size()));
    nbad = 0;
    for (int i = 0; i < exp_data.size() && i < wr_data_log.size(); i++)
      if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i] ||
          wr_be_log[i] !== 4'hF) nbad++;
    check($sformatf("%s:write_mismatches", name), 32'(nbad), 32'd0);
    if (gap == 0) check($sformatf("%s:ready_low_cycles", name), 32'(stalls), 32'(exp_words * CYC));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] part[$];
    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    check("rst:rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst:chipselect", 32'(bus.mem_chipselect), 32'd0);
    check("rst:write", 32'(bus.mem_write), 32'd0);
    check("rst:address", 32'(bus.mem_address), 32'd0);
    check("rst:writedata", bus.mem_writedata, 32'd0);
    check("rst:byteenable", 32'(bus.mem_byteenable), 32'hF);
    check("rst:cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst:load_done", 32'(load_done), 32'd0);
    check("rst:load_err", 32'(load_err), 32'd0);
    check("rst:words_loaded", 32'(words_loaded), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference frame; payload sum 0x264 -> checksum byte 0x64.
    frm = '{8'h13, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    run_frame(0, "ref_good");
    check("ref_good:word0", wr_data_log.size() > 0 ? wr_data_log[0] : 32'hX, 32'h44332211);
    check("ref_good:word1", wr_data_log.size() > 1 ? wr_data_log[1] : 32'hX, 32'h88776655);

    frm = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'hCD};
    run_frame(1, "ref_badck");

    frm = '{8'hA5, 8'h00, 8'h00};
    run_frame(0, "len_zero");
    frm = '{8'hA5, 8'h01, 8'h14};
    run_frame(0, "len_5121");
    build_frame(2, $urandom_range(DEPTH + 1, 65535), 1'b0);
    run_frame(1, "len_big");

    // Idle gap inside DATA must abort after the timeout.
    frm = '{8'hA5, 8'h01, 8'h00, 8'h5A, 8'hC3};
    wr_data_log.delete();
    send_stream(frm, 0);
    repeat (TMO / 2) @(negedge clk);
    check("tmo:err_early", 32'(load_err), 32'd0);
    check("tmo:hold_early", 32'(cpu_hold), 32'd1);
    repeat (TMO) @(negedge clk);
    check("tmo:load_err", 32'(load_err), 32'd1);
    check("tmo:load_done", 32'(load_done), 32'd0);
    check("tmo:cpu_hold", 32'(cpu_hold), 32'd0);
    check("tmo:n_writes", 32'(wr_data_log.size()), 32'd0);

    // Reset asserted between clock edges in the middle of DATA.
    build_frame(0, 3, 1'b0);
    part = frm[0:8];
    send_stream(part, 0);
    check("mid:hold_before", 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid:cpu_hold", 32'(cpu_hold), 32'd0);
    check("mid:words_loaded", 32'(words_loaded), 32'd0);
    check("mid:address", 32'(bus.mem_address), 32'd0);
    check("mid:chipselect", 32'(bus.mem_chipselect), 32'd0);
    check("mid:writedata", bus.mem_writedata, 32'd0);
    check("mid:rx_ready", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    build_frame(1, 4, 1'b0);
    run_frame(0, "post_rst");

    for (int n = 0; n < 10; n++) begin
      build_frame($urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, 3) == 0);
      run_frame($urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    // Largest accepted image, streamed back-to-back.
    build_frame(0, DEPTH, 1'b0);
    run_frame(0, "len_depth");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
